// File: rtl/axil_cfg_master.sv
`default_nettype none
// ============================================================================
// Module      : axil_cfg_master
// Description : AXI4-Lite configuration master. Holds NUM_REGS 32-bit shadow
//               registers, and on start writes a snapshot of them to byte
//               offsets 0,4,8,... of an AXI4-Lite slave. With verify_en set
//               at start, it reads each register back and compares it against
//               the snapshot. Each channel handshake has a bounded wait.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               cfg_we/idx/wdata    - shadow register write port
//               start, verify_en    - sequence launch (verify sampled at start)
//               busy, done          - sequence in progress / end pulse
//               err, err_code/idx   - sticky error status
//               m_axi_aw*/w*/b*     - AXI4-Lite write channels
//               m_axi_ar*/r*        - AXI4-Lite read channels
// Revision    : 1.0 - initial release
// ============================================================================
module axil_cfg_master #(
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_idx,
    input  logic [31:0]       cfg_wdata,
    input  logic              start,
    input  logic              verify_en,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        err_code,
    output logic [1:0]        err_idx,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [2:0]        m_axi_arprot,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    localparam int         c_CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [1:0] c_LAST_IDX = 2'(NUM_REGS - 1);

    localparam logic [2:0] c_ERR_NONE  = 3'd0;
    localparam logic [2:0] c_ERR_BRESP = 3'd1;
    localparam logic [2:0] c_ERR_RRESP = 3'd2;
    localparam logic [2:0] c_ERR_MISM  = 3'd3;
    localparam logic [2:0] c_ERR_TMO   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_RESP = 3'd4,
        S_FIN     = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [31:0]          r_shadow [NUM_REGS];
    logic [31:0]          r_copy   [NUM_REGS];
    logic [1:0]           r_idx;
    logic [1:0]           w_idx_nxt;
    logic                 r_verify;
    logic                 r_aw_done;
    logic                 r_w_done;
    logic [c_CNT_W-1:0]   r_tmo_cnt;
    logic                 r_err;
    logic [2:0]           r_err_code;
    logic [1:0]           r_err_idx;

    logic                 w_start_acc;
    logic                 w_aw_hs;
    logic                 w_w_hs;
    logic                 w_wr_both;
    logic                 w_tmo_hit;
    logic                 w_pending;
    logic                 w_err_set;
    logic [2:0]           w_err_code;

    // Start is only honoured from IDLE; a start during a sequence is dropped.
    assign w_start_acc = start && (r_state == S_IDLE);

    assign w_aw_hs   = m_axi_awvalid && m_axi_awready;
    assign w_w_hs    = m_axi_wvalid && m_axi_wready;
    // Both write handshakes complete, in this cycle or an earlier one.
    assign w_wr_both = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
    assign w_tmo_hit = (r_tmo_cnt == c_TMO_LAST);

    // Master channel outputs are decoded straight from registered state.
    assign m_axi_awaddr  = ADDR_W'({r_idx, 2'b00});
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = (r_state == S_WR_REQ) && !r_aw_done;
    assign m_axi_wdata   = r_copy[r_idx];
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = (r_state == S_WR_REQ) && !r_w_done;
    assign m_axi_bready  = (r_state == S_WR_RESP);
    assign m_axi_araddr  = ADDR_W'({r_idx, 2'b00});
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = (r_state == S_RD_REQ);
    assign m_axi_rready  = (r_state == S_RD_RESP);

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_FIN);
    assign err      = r_err;
    assign err_code = r_err_code;
    assign err_idx  = r_err_idx;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_err_set   = 1'b0;
        w_err_code  = c_ERR_NONE;
        w_pending   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_WR_REQ;
                    w_idx_nxt   = 2'd0;
                end
            end
            S_WR_REQ: begin
                w_pending = !w_wr_both;
                if (w_wr_both) begin
                    w_state_nxt = S_WR_RESP;
                end else if (w_tmo_hit) begin
                    w_err_set   = 1'b1;
                    w_err_code  = c_ERR_TMO;
                    w_state_nxt = S_FIN;
                end
            end
            S_WR_RESP: begin
                w_pending = !m_axi_bvalid;
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) begin
                        w_err_set   = 1'b1;
                        w_err_code  = c_ERR_BRESP;
                        w_state_nxt = S_FIN;
                    end else if (r_idx != c_LAST_IDX) begin
                        w_idx_nxt   = r_idx + 2'd1;
                        w_state_nxt = S_WR_REQ;
                    end else if (r_verify) begin
                        w_idx_nxt   = 2'd0;
                        w_state_nxt = S_RD_REQ;
                    end else begin
                        w_state_nxt = S_FIN;
                    end
                end else if (w_tmo_hit) begin
                    w_err_set   = 1'b1;
                    w_err_code  = c_ERR_TMO;
                    w_state_nxt = S_FIN;
                end
            end
            S_RD_REQ: begin
                w_pending = !m_axi_arready;
                if (m_axi_arready) begin
                    w_state_nxt = S_RD_RESP;
                end else if (w_tmo_hit) begin
                    w_err_set   = 1'b1;
                    w_err_code  = c_ERR_TMO;
                    w_state_nxt = S_FIN;
                end
            end
            S_RD_RESP: begin
                w_pending = !m_axi_rvalid;
                if (m_axi_rvalid) begin
                    // A bad response outranks a data compare on the same beat.
                    if (m_axi_rresp != 2'b00) begin
                        w_err_set   = 1'b1;
                        w_err_code  = c_ERR_RRESP;
                        w_state_nxt = S_FIN;
                    end else if (m_axi_rdata != r_copy[r_idx]) begin
                        w_err_set   = 1'b1;
                        w_err_code  = c_ERR_MISM;
                        w_state_nxt = S_FIN;
                    end else if (r_idx != c_LAST_IDX) begin
                        w_idx_nxt   = r_idx + 2'd1;
                        w_state_nxt = S_RD_REQ;
                    end else begin
                        w_state_nxt = S_FIN;
                    end
                end else if (w_tmo_hit) begin
                    w_err_set   = 1'b1;
                    w_err_code  = c_ERR_TMO;
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, handshake tracking, timeout and error status
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= 2'd0;
            r_verify   <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_tmo_cnt  <= '0;
            r_err      <= 1'b0;
            r_err_code <= c_ERR_NONE;
            r_err_idx  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;

            if (w_start_acc) begin
                r_verify <= verify_en;
            end

            // Per-channel completion flags live only inside one WR_REQ visit,
            // letting AW and W retire independently of each other.
            if ((r_state == S_WR_REQ) && (w_state_nxt == S_WR_REQ)) begin
                r_aw_done <= r_aw_done || w_aw_hs;
                r_w_done  <= r_w_done  || w_w_hs;
            end else begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end

            // Restart the wait budget on every state change.
            if (w_state_nxt != r_state) begin
                r_tmo_cnt <= '0;
            end else if (w_pending) begin
                r_tmo_cnt <= r_tmo_cnt + c_CNT_W'(1);
            end

            if (w_start_acc) begin
                r_err      <= 1'b0;
                r_err_code <= c_ERR_NONE;
                r_err_idx  <= 2'd0;
            end else if (w_err_set) begin
                r_err      <= 1'b1;
                r_err_code <= w_err_code;
                r_err_idx  <= r_idx;
            end
        end
    end

    // Shadow registers accept writes at any time.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_shadow[i] <= 32'd0;
            end
        end else if (cfg_we && (int'(cfg_idx) < NUM_REGS)) begin
            r_shadow[cfg_idx] <= cfg_wdata;
        end
    end

    // Snapshot used by the running sequence; later shadow writes do not
    // disturb it.
    always_ff @(posedge clk) begin
        if (w_start_acc) begin
            r_copy <= r_shadow;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axil_cfg_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_cfg_master
// Description : Directed self-checking bench for axil_cfg_master with a
//               reactive AXI4-Lite register-file slave and channel monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_cfg_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = 2'd0;
    logic [31:0] cfg_wdata = 32'd0;
    logic        start = 1'b0;
    logic        verify_en = 1'b0;
    logic        busy, done, err;
    logic [2:0]  err_code;
    logic [1:0]  err_idx;
    logic [3:0]  m_axi_awaddr, m_axi_araddr;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awready = 1'b0;
    logic        m_axi_wready = 1'b0;
    logic [1:0]  m_axi_bresp = 2'b00;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_arready = 1'b0;
    logic [31:0] m_axi_rdata = 32'd0;
    logic [1:0]  m_axi_rresp = 2'b00;
    logic        m_axi_rvalid = 1'b0;

    axil_cfg_master #(.ADDR_W(4), .NUM_REGS(4), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_wdata(cfg_wdata),
        .start(start), .verify_en(verify_en),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .err_idx(err_idx),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    logic [31:0] vals [4] = '{32'd3, 32'h00040602, 32'h000202FE, 32'h0006FFFE};

    // Slave behaviour knobs (written only by the stimulus process).
    int aw_delay = 0;
    int w_delay = 0;
    int bresp_err_idx = -1;
    int corrupt_idx = -1;
    bit ar_never = 1'b0;

    // Slave / monitor state (written only by the slave process).
    int aw_wait = 0, w_wait = 0;
    bit have_aw = 0, have_w = 0;
    logic [3:0]  cap_aw = 4'd0, cap_ar = 4'd0;
    logic [31:0] cap_w = 32'd0;
    logic [31:0] mem [4];
    bit p_awv = 0, p_wv = 0, p_arv = 0;
    bit p_awhs = 0, p_whs = 0, p_arhs = 0, p_bhs = 0, p_rhs = 0;
    logic [31:0] aw_log [128];
    logic [31:0] w_log  [128];
    logic [31:0] ar_log [128];
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, done_cnt = 0;
    int drop_viol = 0, w_order_viol = 0, w_early = 0, arv_cycles = 0;

    // Bases captured at the start of each sequence.
    int b_aw, b_w, b_ar, b_done, b_drop, b_wo, b_we, b_arv;

    int checks = 0;
    int failures = 0;

    // Reactive slave: drives on the falling edge, so everything it sets is
    // stable at the next rising edge where the DUT samples it.
    always @(negedge clk) begin
        if (rst) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
            m_axi_arready = 0; m_axi_rvalid = 0;
            have_aw = 0; have_w = 0; aw_wait = 0; w_wait = 0;
            p_awv = 0; p_wv = 0; p_arv = 0;
            p_awhs = 0; p_whs = 0; p_arhs = 0; p_bhs = 0; p_rhs = 0;
            for (int i = 0; i < 4; i++) mem[i] = 32'd0;
        end else begin
            if (p_awv && !p_awhs && !m_axi_awvalid) drop_viol++;
            if (p_wv  && !p_whs  && !m_axi_wvalid)  drop_viol++;
            if (p_arv && !p_arhs && !m_axi_arvalid) drop_viol++;
            // W finished alone: W must now be low while AW keeps waiting.
            if (p_whs && !have_aw) begin
                w_early++;
                if (!(m_axi_awvalid && !m_axi_wvalid)) w_order_viol++;
            end
            if (done) done_cnt++;
            if (m_axi_arvalid) arv_cycles++;

            if (p_bhs) m_axi_bvalid = 0;
            if (p_rhs) m_axi_rvalid = 0;
            if (have_aw && have_w) begin
                mem[cap_aw[3:2]] = cap_w;
                m_axi_bvalid = 1;
                m_axi_bresp = (int'(cap_aw[3:2]) == bresp_err_idx) ? 2'b10 : 2'b00;
                have_aw = 0; have_w = 0;
            end
            if (p_arhs) begin
                m_axi_rvalid = 1;
                m_axi_rresp = 2'b00;
                m_axi_rdata = mem[cap_ar[3:2]] ^ ((int'(cap_ar[3:2]) == corrupt_idx) ? 32'd1 : 32'd0);
            end

            m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
            if (m_axi_awvalid && !m_axi_awready) aw_wait++; else aw_wait = 0;
            m_axi_wready = m_axi_wvalid && (w_wait >= w_delay);
            if (m_axi_wvalid && !m_axi_wready) w_wait++; else w_wait = 0;
            m_axi_arready = m_axi_arvalid && !ar_never;

            p_awhs = m_axi_awvalid && m_axi_awready;
            p_whs  = m_axi_wvalid && m_axi_wready;
            p_arhs = m_axi_arvalid && m_axi_arready;
            p_bhs  = m_axi_bvalid && m_axi_bready;
            p_rhs  = m_axi_rvalid && m_axi_rready;
            if (p_awhs) begin
                have_aw = 1; cap_aw = m_axi_awaddr;
                if (aw_cnt < 128) aw_log[aw_cnt] = 32'(m_axi_awaddr);
                aw_cnt++;
            end
            if (p_whs) begin
                have_w = 1; cap_w = m_axi_wdata;
                if (w_cnt < 128) w_log[w_cnt] = m_axi_wdata;
                w_cnt++;
            end
            if (p_arhs) begin
                cap_ar = m_axi_araddr;
                if (ar_cnt < 128) ar_log[ar_cnt] = 32'(m_axi_araddr);
                ar_cnt++;
            end
            p_awv = m_axi_awvalid; p_wv = m_axi_wvalid; p_arv = m_axi_arvalid;
        end
    end

    task automatic load_regs;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cfg_we = 1; cfg_idx = 2'(i); cfg_wdata = vals[i];
        end
        @(negedge clk);
        cfg_we = 0;
    endtask

    task automatic take_bases;
        b_aw = aw_cnt; b_w = w_cnt; b_ar = ar_cnt; b_done = done_cnt;
        b_drop = drop_viol; b_wo = w_order_viol; b_we = w_early; b_arv = arv_cycles;
    endtask

    task automatic wait_done;
        bit got;
        got = 0;
        for (int i = 0; i < 2000; i++) begin
            if (done === 1'b1) begin got = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!got) begin failures++; $display("FAIL done_wait: got no done, expected done within 2000 cycles"); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL after_done: got busy=%b done=%b expected 0 0", busy, done);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_seq(input logic ver);
        take_bases();
        @(negedge clk);
        start = 1; verify_en = ver;
        @(negedge clk);
        start = 0; verify_en = 0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL busy_after_start: got %b expected 1", busy); end
        wait_done();
    endtask

    task automatic check_writes(input string tag);
        checks++;
        if (aw_cnt - b_aw != 4 || w_cnt - b_w != 4) begin
            failures++; $display("FAIL %s_wr_count: got aw=%0d w=%0d expected 4 4", tag, aw_cnt - b_aw, w_cnt - b_w);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (aw_log[b_aw+i] !== 32'(i*4) || w_log[b_w+i] !== vals[i]) begin
                failures++;
                $display("FAIL %s_wr%0d: got addr=%0h data=%0h expected addr=%0h data=%0h",
                         tag, i, aw_log[b_aw+i], w_log[b_w+i], i*4, vals[i]);
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err} !== 3'b000) begin failures++; $display("FAIL rst_status: got %b expected 000", {busy, done, err}); end
        checks++;
        if (err_code !== 3'd0 || err_idx !== 2'd0) begin
            failures++; $display("FAIL rst_err_fields: got code=%0d idx=%0d expected 0 0", err_code, err_idx);
        end
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready} !== 5'b0) begin
            failures++; $display("FAIL rst_channels: got %b expected 00000",
                {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready});
        end
        rst = 0;
        // Unloaded shadow registers must write zeros.
        run_seq(0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (w_log[b_w+i] !== 32'd0) begin failures++; $display("FAIL rst_shadow%0d: got %0h expected 0", i, w_log[b_w+i]); end
        end
    endtask

    task automatic test_write_only;
        load_regs();
        run_seq(0);
        check_writes("wo");
        checks++;
        if (ar_cnt != b_ar || done_cnt - b_done != 1 || err !== 1'b0) begin
            failures++; $display("FAIL wo_misc: got ar=%0d done=%0d err=%b expected 0 1 0", ar_cnt - b_ar, done_cnt - b_done, err);
        end
        checks++;
        if (m_axi_wstrb !== 4'hF || m_axi_awprot !== 3'd0 || m_axi_arprot !== 3'd0) begin
            failures++; $display("FAIL wo_const: got wstrb=%h awprot=%0d arprot=%0d expected f 0 0", m_axi_wstrb, m_axi_awprot, m_axi_arprot);
        end
    endtask

    task automatic test_verify;
        run_seq(1);
        check_writes("vf");
        checks++;
        if (ar_cnt - b_ar != 4) begin failures++; $display("FAIL vf_rd_count: got %0d expected 4", ar_cnt - b_ar); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ar_log[b_ar+i] !== 32'(i*4)) begin failures++; $display("FAIL vf_rd%0d: got %0h expected %0h", i, ar_log[b_ar+i], i*4); end
        end
        checks++;
        if (done_cnt - b_done != 1 || err !== 1'b0 || err_code !== 3'd0) begin
            failures++; $display("FAIL vf_status: got done=%0d err=%b code=%0d expected 1 0 0", done_cnt - b_done, err, err_code);
        end
    endtask

    task automatic test_aw_late;
        aw_delay = 3;
        run_seq(0);
        aw_delay = 0;
        check_writes("awl");
        checks++;
        if (w_early - b_we != 4 || w_order_viol != b_wo) begin
            failures++; $display("FAIL awl_order: got early=%0d viol=%0d expected 4 0", w_early - b_we, w_order_viol - b_wo);
        end
        checks++;
        if (drop_viol != b_drop) begin failures++; $display("FAIL awl_drop: got %0d expected 0", drop_viol - b_drop); end
    endtask

    task automatic test_back_to_back;
        take_bases();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        @(negedge clk); start = 1; cfg_we = 1; cfg_idx = 2'd0; cfg_wdata = 32'h11;
        @(negedge clk); start = 0; cfg_we = 0;
        wait_done();
        repeat (10) @(negedge clk);
        checks++;
        if (aw_cnt - b_aw != 4 || done_cnt - b_done != 1) begin
            failures++; $display("FAIL b2b_ignore: got aw=%0d done=%0d expected 4 1", aw_cnt - b_aw, done_cnt - b_done);
        end
        checks++;
        if (w_log[b_w] !== 32'd3) begin failures++; $display("FAIL b2b_snapshot: got %0h expected 3", w_log[b_w]); end
        run_seq(0);
        checks++;
        if (w_log[b_w] !== 32'h11) begin failures++; $display("FAIL b2b_next: got %0h expected 11", w_log[b_w]); end
        load_regs();
    endtask

    task automatic test_bresp_err;
        bresp_err_idx = 2;
        run_seq(0);
        bresp_err_idx = -1;
        checks++;
        if (err !== 1'b1 || err_code !== 3'd1 || err_idx !== 2'd2) begin
            failures++; $display("FAIL bresp_status: got err=%b code=%0d idx=%0d expected 1 1 2", err, err_code, err_idx);
        end
        checks++;
        if (aw_cnt - b_aw != 3 || done_cnt - b_done != 1) begin
            failures++; $display("FAIL bresp_stop: got aw=%0d done=%0d expected 3 1", aw_cnt - b_aw, done_cnt - b_done);
        end
    endtask

    task automatic test_mismatch;
        corrupt_idx = 1;
        run_seq(1);
        corrupt_idx = -1;
        checks++;
        if (err !== 1'b1 || err_code !== 3'd3 || err_idx !== 2'd1) begin
            failures++; $display("FAIL mism_status: got err=%b code=%0d idx=%0d expected 1 3 1", err, err_code, err_idx);
        end
        checks++;
        if (ar_cnt - b_ar != 2) begin failures++; $display("FAIL mism_reads: got %0d expected 2", ar_cnt - b_ar); end
        repeat (5) @(negedge clk);
        checks++;
        if (err !== 1'b1 || err_code !== 3'd3) begin
            failures++; $display("FAIL mism_sticky: got err=%b code=%0d expected 1 3", err, err_code);
        end
    endtask

    task automatic test_timeout;
        ar_never = 1;
        run_seq(1);
        ar_never = 0;
        checks++;
        if (err !== 1'b1 || err_code !== 3'd4 || err_idx !== 2'd0) begin
            failures++; $display("FAIL tmo_status: got err=%b code=%0d idx=%0d expected 1 4 0", err, err_code, err_idx);
        end
        checks++;
        if (arv_cycles - b_arv != 255) begin failures++; $display("FAIL tmo_cycles: got %0d expected 255", arv_cycles - b_arv); end
        checks++;
        if (drop_viol - b_drop != 1) begin failures++; $display("FAIL tmo_drop: got %0d expected 1", drop_viol - b_drop); end
        run_seq(0);
        checks++;
        if (err !== 1'b0 || err_code !== 3'd0 || err_idx !== 2'd0) begin
            failures++; $display("FAIL tmo_clear: got err=%b code=%0d idx=%0d expected 0 0 0", err, err_code, err_idx);
        end
    endtask

    task automatic test_rst_abort;
        bit seen;
        take_bases();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            if (m_axi_awvalid === 1'b1) begin seen = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL rsta_aw: got no awvalid expected awvalid"); end
        rst = 1;
        @(negedge clk);
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, busy, done} !== 5'b0) begin
            failures++; $display("FAIL rsta_abort: got %b expected 00000",
                {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, busy, done});
        end
        @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt != b_done) begin failures++; $display("FAIL rsta_nodone: got %0d expected 0", done_cnt - b_done); end
        load_regs();
        run_seq(0);
        check_writes("rsta");
        checks++;
        if (err !== 1'b0 || done_cnt - b_done != 1) begin
            failures++; $display("FAIL rsta_clean: got err=%b done=%0d expected 0 1", err, done_cnt - b_done);
        end
    endtask

    initial begin
        test_reset();
        test_write_only();
        test_verify();
        test_aw_late();
        test_back_to_back();
        test_bresp_err();
        test_mismatch();
        test_timeout();
        test_rst_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
